key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable samples required to accept a press or release (10 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning cycles from accepted press to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning cycles between later auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port key_n  input  1  raw pushbutton, active-low (pressed=0), asynchronous to clk, bouncing.
REQ-007 SHALL have port pulse  output  1  one-cycle strobe per accepted press (and per repeat); drives counter en.
REQ-008 SHALL have port level  output  1  debounced key state, 1=pressed.
REQ-009 SHALL have port busy  output  1  high while a press or release is being qualified.

Function
REQ-010 SHALL pass key_n through a 2-flop synchronizer; key_s = ~key_n after 2 clk cycles.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, REL_WAIT; a stable-sample counter is sized $clog2 of the largest parameter.
REQ-012 SHALL in IDLE: on key_s=1 go to PRESS_WAIT with counter=1; otherwise stay.
REQ-013 SHALL in PRESS_WAIT: key_s=0 returns to IDLE with counter cleared (bounce rejected, no pulse); counter reaching DEBOUNCE_CYCLES goes to HELD.
REQ-014 SHALL assert pulse for exactly one cycle, the cycle HELD is entered; level rises in that same cycle.
REQ-015 SHALL in HELD: key_s=0 goes to REL_WAIT with counter=1; otherwise stay.
REQ-016 SHALL in REL_WAIT: key_s=1 returns to HELD (no pulse, repeat timing resumes); counter reaching DEBOUNCE_CYCLES goes to IDLE and level falls.
REQ-017 SHALL make busy = (state==PRESS_WAIT || state==REL_WAIT).
REQ-018 SHALL guarantee at most one non-repeat pulse per press-release cycle, whatever the bounce pattern.
REQ-019 SHALL register all outputs; latency from a clean key_n fall to pulse is 2+DEBOUNCE_CYCLES cycles.
REQ-020 SHALL saturate counters, never wrap; DEBOUNCE_CYCLES<1 is illegal (elaboration error).

Reset
REQ-021 SHALL with clr=1 at a clk edge force state=IDLE, counters=0, synchronizer flops=0 (released), pulse=0, level=0, busy=0.
REQ-022 SHALL give clr priority over every transition; clr mid-PRESS_WAIT or mid-HELD emits no pulse.
REQ-023 SHALL, if the key is held across a clr release, re-qualify it as a new press (one pulse after 2+DEBOUNCE_CYCLES cycles).

Configuration
REQ-024 SHALL with macro KEY_PULSE_REPEAT_EN defined: while in HELD, emit a pulse REPEAT_DELAY cycles after entering HELD, then every REPEAT_PERIOD cycles until leaving HELD.
REQ-025 SHALL with KEY_PULSE_REPEAT_EN undefined: omit the repeat timer entirely; exactly one pulse per accepted press; REPEAT_* parameters are ignored.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, REL_WAIT=2'd3) in shared package key_if_pkg.
REQ-027 SHALL place the synchronizer in sub-module sync_2ff (reset value parameterised), reusable by other board interfaces.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-028 SHALL cover clean press: key_n held 0 for 20 cycles -> pulse high exactly once, at cycle 6 after the fall; level=1 from cycle 6.
REQ-029 SHALL cover bounce: key_n toggles 0/1 every 2 cycles for 12 cycles, then returns to 1 -> pulse never asserted; busy toggles; level stays 0.
REQ-030 SHALL cover a release glitch: press accepted, then key_n=1 for 2 cycles, then 0 again -> no second pulse; level stays 1.
REQ-031 SHALL cover reset mid-qualify: clr pulsed 1 cycle during PRESS_WAIT, key still held -> no pulse until 6 cycles after clr falls, then exactly one.
REQ-032 SHALL cover repeat with KEY_PULSE_REPEAT_EN defined: key held 20 cycles after acceptance -> pulses at acceptance, +8, +11, +14, +17, +20.
REQ-033 SHALL cover the counter chain: pulse drives counter_4bit_sync en for 16 accepted presses -> count wraps 15->0 and is_all_zero=1.

Source files
------------

// File: rtl/key_if_pkg.sv
// Shared definitions for board key/button interfaces: FSM state encoding and
// counter sizing helpers.
package key_if_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } keyState_t;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // $clog2(n) alone cannot hold n itself when n is a power of two, hence the +1.
   function automatic int cntWidth(input int maxVal);
      int w;
      w = $clog2(maxVal + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// RESET_VAL lets each board interface pick its idle level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_meta <= RESET_VAL;
         r_q    <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounces an active-low pushbutton into a one-cycle pulse plus level/busy flags.
// Define KEY_PULSE_REPEAT_EN to add auto-repeat pulses while the key stays held.
module key_pulse_gen
   import key_if_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic clr,
   input  logic key_n,
   output logic pulse,
   output logic level,
   output logic busy
);

   localparam int CNT_W = cntWidth(maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
         $error("key_pulse_gen: DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   keyState_t        r_state;
   keyState_t        w_stateNext;
   logic [CNT_W-1:0] r_debCnt;
   logic [CNT_W-1:0] w_debCntNext;
   logic             w_keyRaw;
   logic             w_keyS;
   logic             w_enterHeld;
   logic             w_rptFire;
   logic             r_pulse;
   logic             r_level;
   logic             r_busy;
   logic             w_pulseNext;
   logic             w_levelNext;
   logic             w_busyNext;

   assign w_keyRaw = ~key_n;

   sync_2ff #(
      .RESET_VAL(1'b0)
   ) u_keySync (
      .clk(clk),
      .clr(clr),
      .i_d(w_keyRaw),
      .o_q(w_keyS)
   );

   // r_debCnt holds the stable samples seen so far; the sample that would make it
   // DEBOUNCE_CYCLES commits the transition, so DEB_LAST == 0 means one sample suffices.
   always_comb begin
      w_stateNext  = r_state;
      w_debCntNext = r_debCnt;
      w_enterHeld  = 1'b0;
      case (r_state)
         IDLE: begin
            w_debCntNext = '0;
            if (w_keyS) begin
               if (DEB_LAST == '0) begin
                  w_stateNext = HELD;
                  w_enterHeld = 1'b1;
               end else begin
                  w_stateNext  = PRESS_WAIT;
                  w_debCntNext = CNT_ONE;
               end
            end
         end
         PRESS_WAIT: begin
            if (!w_keyS) begin
               w_stateNext  = IDLE;
               w_debCntNext = '0;
            end else if (r_debCnt >= DEB_LAST) begin
               w_stateNext  = HELD;
               w_debCntNext = '0;
               w_enterHeld  = 1'b1;
            end else if (r_debCnt != '1) begin
               w_debCntNext = r_debCnt + CNT_ONE;
            end
         end
         HELD: begin
            w_debCntNext = '0;
            if (!w_keyS) begin
               if (DEB_LAST == '0) begin
                  w_stateNext = IDLE;
               end else begin
                  w_stateNext  = REL_WAIT;
                  w_debCntNext = CNT_ONE;
               end
            end
         end
         REL_WAIT: begin
            if (w_keyS) begin
               w_stateNext  = HELD;
               w_debCntNext = '0;
            end else if (r_debCnt >= DEB_LAST) begin
               w_stateNext  = IDLE;
               w_debCntNext = '0;
            end else if (r_debCnt != '1) begin
               w_debCntNext = r_debCnt + CNT_ONE;
            end
         end
         default: begin
            w_stateNext  = IDLE;
            w_debCntNext = '0;
         end
      endcase
   end

`ifdef KEY_PULSE_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_DELAY_LD  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_PERIOD_LD = CNT_W'(REPEAT_PERIOD);

   generate
      if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badRepeat
         $error("key_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] r_rptCnt;
   logic [CNT_W-1:0] w_rptCntNext;

   // Countdown to the next repeat; it only runs on cycles spent settled in HELD,
   // so a release glitch through REL_WAIT pauses it rather than restarting it.
   always_comb begin
      w_rptCntNext = r_rptCnt;
      w_rptFire    = 1'b0;
      if (w_enterHeld) begin
         w_rptCntNext = RPT_DELAY_LD;
      end else if (r_state == HELD && w_stateNext == HELD) begin
         if (r_rptCnt <= CNT_ONE) begin
            w_rptFire    = 1'b1;
            w_rptCntNext = RPT_PERIOD_LD;
         end else begin
            w_rptCntNext = r_rptCnt - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_rptCnt <= '0;
      end else begin
         r_rptCnt <= w_rptCntNext;
      end
   end
`else
   assign w_rptFire = 1'b0;
`endif

   assign w_pulseNext = w_enterHeld | w_rptFire;
   assign w_levelNext = (w_stateNext == HELD) || (w_stateNext == REL_WAIT);
   assign w_busyNext  = (w_stateNext == PRESS_WAIT) || (w_stateNext == REL_WAIT);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state  <= IDLE;
         r_debCnt <= '0;
         r_pulse  <= 1'b0;
         r_level  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_debCnt <= w_debCntNext;
         r_pulse  <= w_pulseNext;
         r_level  <= w_levelNext;
         r_busy   <= w_busyNext;
      end
   end

   assign pulse = r_pulse;
   assign level = r_level;
   assign busy  = r_busy;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen; compile with +define+KEY_PULSE_REPEAT_EN
// to exercise the auto-repeat build.
module tb_key_pulse_gen;

   localparam int DEB  = 4;
   localparam int RDLY = 8;
   localparam int RPER = 3;
   localparam int ACC  = DEB + 2;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic key_n = 1'b1;
   logic pulse;
   logic level;
   logic busy;

   int compared = 0;
   int mismatched = 0;

   // Reference model state: synchronizer pipe, debounced level, run of
   // disagreeing samples, and settled-held cycles since acceptance.
   bit mS1 = 1'b0;
   bit mS2 = 1'b0;
   bit mLevel = 1'b0;
   int mRun = 0;
   int mHeld = 0;
   bit expPulse = 1'b0;
   bit expBusy = 1'b0;

   key_pulse_gen #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY(RDLY),
      .REPEAT_PERIOD(RPER)
   ) dut (
      .clk(clk),
      .clr(clr),
      .key_n(key_n),
      .pulse(pulse),
      .level(level),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic modelEdge(input bit keyN, input bit clrVal);
      bit ks;
      if (clrVal) begin
         mS1 = 1'b0; mS2 = 1'b0; mLevel = 1'b0;
         mRun = 0; mHeld = 0; expPulse = 1'b0; expBusy = 1'b0;
         return;
      end
      ks = mS2;
      mS2 = mS1;
      mS1 = ~keyN;
      expPulse = 1'b0;
      if (ks != mLevel) begin
         mRun++;
         if (mRun >= DEB) begin
            mLevel = ks;
            mRun = 0;
            mHeld = 0;
            expPulse = mLevel;
         end
      end else begin
`ifdef KEY_PULSE_REPEAT_EN
         if (mLevel && mRun == 0) begin
            mHeld++;
            if (mHeld == RDLY || (mHeld > RDLY && (mHeld - RDLY) % RPER == 0)) expPulse = 1'b1;
         end
`endif
         mRun = 0;
      end
      expBusy = (mRun != 0);
   endtask

   // Drive inputs at the falling edge, advance the model on the rising edge,
   // then return at the next falling edge where outputs are sampled.
   task automatic applyStimulus(input bit keyN, input bit clrVal);
      key_n = keyN;
      clr = clrVal;
      @(posedge clk);
      modelEdge(keyN, clrVal);
      @(negedge clk);
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      for (int cyc = 1; cyc <= 4; cyc++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'b1);
         compared += 3;
         if (pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.pulse cyc=%0d got=%b exp=0", cyc, pulse); end
         if (level !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.level cyc=%0d got=%b exp=0", cyc, level); end
         if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.busy cyc=%0d got=%b exp=0", cyc, busy); end
      end
      settle(4);
      compared++;
      if (level !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.idleLevel got=%b exp=0", level); end
   endtask

   task automatic test_clean_press();
      int pulseCount;
      int wantCount;
      bit wantPulse;
      pulseCount = 0;
      settle(10);
      for (int cyc = 1; cyc <= ACC + 20; cyc++) begin
         applyStimulus(1'b0, 1'b0);
         wantPulse = (cyc == ACC);
`ifdef KEY_PULSE_REPEAT_EN
         if (cyc == ACC + 8 || cyc == ACC + 11 || cyc == ACC + 14 || cyc == ACC + 17 || cyc == ACC + 20) wantPulse = 1'b1;
`endif
         if (pulse === 1'b1) pulseCount++;
         compared += 3;
         if (pulse !== wantPulse) begin mismatched++; $display("[TB] FAIL clean.pulse cyc=%0d got=%b exp=%b", cyc, pulse, wantPulse); end
         if (level !== (cyc >= ACC)) begin mismatched++; $display("[TB] FAIL clean.level cyc=%0d got=%b exp=%b", cyc, level, (cyc >= ACC)); end
         if (busy !== expBusy) begin mismatched++; $display("[TB] FAIL clean.busy cyc=%0d got=%b exp=%b", cyc, busy, expBusy); end
      end
`ifdef KEY_PULSE_REPEAT_EN
      wantCount = 6;
`else
      wantCount = 1;
`endif
      compared++;
      if (pulseCount != wantCount) begin mismatched++; $display("[TB] FAIL clean.count got=%0d exp=%0d", pulseCount, wantCount); end
      for (int cyc = 1; cyc <= 10; cyc++) begin
         applyStimulus(1'b1, 1'b0);
         compared += 2;
         if (level !== mLevel) begin mismatched++; $display("[TB] FAIL clean.relLevel cyc=%0d got=%b exp=%b", cyc, level, mLevel); end
         if (pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL clean.relPulse cyc=%0d got=%b exp=0", cyc, pulse); end
      end
   endtask

   task automatic test_bounce();
      bit sawBusy;
      bit sawBusyDrop;
      bit keyN;
      sawBusy = 1'b0;
      sawBusyDrop = 1'b0;
      settle(10);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         keyN = (cyc > 12) ? 1'b1 : 1'(((cyc - 1) / 2) % 2);
         applyStimulus(keyN, 1'b0);
         if (busy === 1'b1) sawBusy = 1'b1;
         if (sawBusy && busy === 1'b0 && cyc <= 12) sawBusyDrop = 1'b1;
         compared += 3;
         if (pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL bounce.pulse cyc=%0d got=%b exp=0", cyc, pulse); end
         if (level !== 1'b0) begin mismatched++; $display("[TB] FAIL bounce.level cyc=%0d got=%b exp=0", cyc, level); end
         if (busy !== expBusy) begin mismatched++; $display("[TB] FAIL bounce.busy cyc=%0d got=%b exp=%b", cyc, busy, expBusy); end
      end
      compared++;
      if (!(sawBusy && sawBusyDrop)) begin mismatched++; $display("[TB] FAIL bounce.busyToggle got=%b%b exp=11", sawBusy, sawBusyDrop); end
   endtask

   task automatic test_release_glitch();
      int extraPulses;
      bit keyN;
      extraPulses = 0;
      settle(10);
      for (int cyc = 1; cyc <= 22; cyc++) begin
         keyN = (cyc == 9 || cyc == 10);
         applyStimulus(keyN, 1'b0);
         if (cyc > ACC && pulse === 1'b1) extraPulses++;
         compared += 3;
         if (pulse !== expPulse) begin mismatched++; $display("[TB] FAIL glitch.pulse cyc=%0d got=%b exp=%b", cyc, pulse, expPulse); end
         if (level !== (cyc >= ACC)) begin mismatched++; $display("[TB] FAIL glitch.level cyc=%0d got=%b exp=%b", cyc, level, (cyc >= ACC)); end
         if (busy !== expBusy) begin mismatched++; $display("[TB] FAIL glitch.busy cyc=%0d got=%b exp=%b", cyc, busy, expBusy); end
      end
`ifndef KEY_PULSE_REPEAT_EN
      compared++;
      if (extraPulses != 0) begin mismatched++; $display("[TB] FAIL glitch.secondPulse got=%0d exp=0", extraPulses); end
`endif
      settle(10);
   endtask

   task automatic test_reset_mid_qualify();
      settle(10);
      for (int cyc = 1; cyc <= 4; cyc++) applyStimulus(1'b0, 1'b0);
      compared++;
      if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midclr.busyBefore got=%b exp=1", busy); end
      applyStimulus(1'b0, 1'b1);
      compared += 3;
      if (pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL midclr.pulseAtClr got=%b exp=0", pulse); end
      if (level !== 1'b0) begin mismatched++; $display("[TB] FAIL midclr.levelAtClr got=%b exp=0", level); end
      if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midclr.busyAtClr got=%b exp=0", busy); end
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b0);
         compared += 2;
         if (pulse !== (k == ACC)) begin mismatched++; $display("[TB] FAIL midclr.pulse k=%0d got=%b exp=%b", k, pulse, (k == ACC)); end
         if (level !== (k >= ACC)) begin mismatched++; $display("[TB] FAIL midclr.level k=%0d got=%b exp=%b", k, level, (k >= ACC)); end
      end
      settle(10);
   endtask

   task automatic test_counter_chain();
      logic [3:0] cnt4;
      logic isAllZero;
      int totalPulses;
      cnt4 = 4'd0;
      totalPulses = 0;
      settle(10);
      for (int press = 1; press <= 16; press++) begin
         for (int cyc = 1; cyc <= 16; cyc++) begin
            applyStimulus(cyc > 8, 1'b0);
            if (pulse === 1'b1) begin
               cnt4 = cnt4 + 4'd1;
               totalPulses++;
            end
            compared++;
            if (pulse !== expPulse) begin mismatched++; $display("[TB] FAIL chain.pulse press=%0d cyc=%0d got=%b exp=%b", press, cyc, pulse, expPulse); end
         end
         if (press == 15) begin
            compared++;
            if (cnt4 !== 4'd15) begin mismatched++; $display("[TB] FAIL chain.count15 got=%0d exp=15", cnt4); end
         end
      end
      isAllZero = (cnt4 == 4'd0);
      compared += 3;
      if (cnt4 !== 4'd0) begin mismatched++; $display("[TB] FAIL chain.wrap got=%0d exp=0", cnt4); end
      if (isAllZero !== 1'b1) begin mismatched++; $display("[TB] FAIL chain.isAllZero got=%b exp=1", isAllZero); end
      if (totalPulses != 16) begin mismatched++; $display("[TB] FAIL chain.total got=%0d exp=16", totalPulses); end
   endtask

   task automatic test_random();
      int runLen;
      bit keyN;
      bit clrVal;
      int cyc;
      cyc = 0;
      for (int run = 0; run < 300; run++) begin
         runLen = $urandom_range(1, 7);
         keyN = 1'($urandom_range(0, 1));
         for (int i = 0; i < runLen; i++) begin
            clrVal = ($urandom_range(0, 59) == 0);
            applyStimulus(keyN, clrVal);
            cyc++;
            compared += 3;
            if (pulse !== expPulse) begin mismatched++; $display("[TB] FAIL rand.pulse cyc=%0d got=%b exp=%b", cyc, pulse, expPulse); end
            if (level !== mLevel) begin mismatched++; $display("[TB] FAIL rand.level cyc=%0d got=%b exp=%b", cyc, level, mLevel); end
            if (busy !== expBusy) begin mismatched++; $display("[TB] FAIL rand.busy cyc=%0d got=%b exp=%b", cyc, busy, expBusy); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_reset_mid_qualify();
      test_counter_chain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
